// File: rtl/stream_arbiter.sv
// -----------------------------------------------------------------------------
// stream_arbiter
//
// Shares the single-bit Stream input of a tone-detector FSM between NUM_REQ
// requesters. Each requester offers a parallel word; the arbiter picks one
// requester round-robin, shifts its word out MSB-first on Stream, and then
// appends GAP idle cycles. Any response that arrives during those cycles is
// still counted. For the whole frame it counts the cycles in which the FSM
// drives Tone high, and it hands that count back to the winner with a
// one-cycle done pulse.
//
// Frame timing, where t is the edge that grants the frame:
//   t+1 .. t+WORD_W                 word bits on Stream, MSB first
//   t+WORD_W+1 .. t+WORD_W+GAP      Stream = 0 (gap)
//   t+WORD_W+GAP+1                  REPORT: done[winner] pulses
//   t+WORD_W+GAP+2                  IDLE again (earliest next grant edge)
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WORD_W   bits per frame serialized onto Stream
//   GAP      idle cycles appended after each word (0 allowed)
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset; abandons any frame in flight
//   req         per-requester request level, sampled only in IDLE
//   word_in     requester i word at bits [i*WORD_W +: WORD_W]
//   grant       one-hot winner, held from frame start through REPORT
//   done        one-cycle pulse to the winner in the REPORT cycle
//   tone_count  number of Tone cycles seen in the last frame
//   busy        high whenever a frame is in progress (state != IDLE)
//   Stream      serial bit to the tone-detector FSM
//   Tone        tone-detected output of the FSM
// -----------------------------------------------------------------------------
module stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8,
    parameter int GAP     = 2,
    localparam int CNT_W  = $clog2(WORD_W + GAP + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   word_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [CNT_W-1:0]            tone_count,
    output logic                        busy,
    output logic                        Stream,
    input  logic                        Tone
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_S  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t              state;
    logic [IDX_W-1:0]    last;       // index of the most recent winner
    logic [WORD_W-1:0]   shift_reg;  // MSB is the bit currently on Stream
    logic [CNT_W-1:0]    bit_cnt;    // position within SHIFT, then within GAP_S
    logic                stream_q;

    // Next-state values
    state_t              state_n;
    logic [NUM_REQ-1:0]  grant_n;
    logic [IDX_W-1:0]    last_n;
    logic [WORD_W-1:0]   shift_n;
    logic [CNT_W-1:0]    cnt_n;
    logic [CNT_W-1:0]    tone_n;
    logic                stream_n;

    // Arbitration result
    logic                found;
    logic [IDX_W-1:0]    pick;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... (mod NUM_REQ) and take the
    // first asserted request. The previous winner is checked last, so a
    // requester that keeps req high after its done has the lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so that no path through the block leaves it
        // unassigned and no latch is inferred.
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        shift_n  = shift_reg;
        cnt_n    = bit_cnt;
        tone_n   = tone_count;
        stream_n = 1'b0;

        // Tone counts only while the frame is on the wire. The largest
        // possible count is WORD_W+GAP, and CNT_W is sized to hold it.
        if ((state == SHIFT || state == GAP_S) && Tone) begin
            tone_n = tone_count + CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n  = SHIFT;
                    grant_n  = NUM_REQ'(1) << pick;
                    last_n   = pick;
                    shift_n  = word_in[pick*WORD_W +: WORD_W];
                    cnt_n    = '0;
                    tone_n   = '0;
                    // The first bit goes to the output register here, so it
                    // appears on Stream in the same cycle as grant.
                    stream_n = word_in[pick*WORD_W + WORD_W - 1];
                end
            end

            SHIFT: begin
                shift_n = shift_reg << 1;
                if (int'(bit_cnt) == WORD_W - 1) begin
                    cnt_n   = '0;
                    state_n = (GAP == 0) ? REPORT : GAP_S;
                end else begin
                    cnt_n    = bit_cnt + CNT_W'(1);
                    stream_n = shift_n[WORD_W-1];
                end
            end

            GAP_S: begin
                if (int'(bit_cnt) == GAP - 1) begin
                    cnt_n   = '0;
                    state_n = REPORT;
                end else begin
                    cnt_n = bit_cnt + CNT_W'(1);
                end
            end

            REPORT: begin
                state_n = IDLE;
                grant_n = '0;
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset clears every register, and the pointer is set so that
    // requester 0 is checked first.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments
        // only, so every register samples the values from before the edge.
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last       <= IDX_W'(NUM_REQ - 1);
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tone_count <= '0;
            stream_q   <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last       <= last_n;
            shift_reg  <= shift_n;
            bit_cnt    <= cnt_n;
            tone_count <= tone_n;
            stream_q   <= stream_n;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Stream = stream_q;
    assign busy   = (state != IDLE);
    assign done   = (state == REPORT) ? grant : '0;

endmodule

// File: tb/tb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_arbiter
//
// Self-checking bench for stream_arbiter at default parameters
// (NUM_REQ=4, WORD_W=8, GAP=2, so a frame period is 12 cycles).
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// the same point, which is away from the edge. A table of per-cycle records
// covers the basic frame and Tone counting. Hand-written sequences cover
// fairness, reset in the middle of a frame, alternation and word capture.
// -----------------------------------------------------------------------------
module tb_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 8;
    localparam int GAP     = 2;
    localparam int CNT_W   = $clog2(WORD_W + GAP + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*WORD_W-1:0] word_in;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [CNT_W-1:0]          tone_count;
    logic                      busy;
    logic                      Stream;
    logic                      Tone;

    int passed = 0;
    int total  = 0;

    stream_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WORD_W (WORD_W),
        .GAP    (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .word_in   (word_in),
        .grant     (grant),
        .done      (done),
        .tone_count(tone_count),
        .busy      (busy),
        .Stream    (Stream),
        .Tone      (Tone)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One record per cycle: the inputs driven during cycle N, and the outputs
    // expected in cycle N+1 after the edge.
    typedef struct {
        logic [3:0]  req;
        logic [31:0] word;
        logic        tone;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        stream;
        logic        busy;
        logic [3:0]  tc;
    } vec_t;

    function automatic vec_t mk(logic [3:0] r, logic [31:0] w, logic t, logic [3:0] g,
                                logic [3:0] d, logic s, logic b, logic [3:0] c);
        vec_t v;
        v.req = r; v.word = w; v.tone = t; v.grant = g;
        v.done = d; v.stream = s; v.busy = b; v.tc = c;
        return v;
    endfunction

    localparam int NVEC = 26;
    vec_t vecs[NVEC];

    initial begin
        int c;
        int done_cnt[NUM_REQ];
        int overlap;
        int early_done;
        logic [7:0] bits;

        // Frame for requester 0 with word A5 = 1010_0101 and Tone low.
        vecs[0]  = mk(4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'd0);
        vecs[1]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[2]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'd0);
        vecs[3]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[4]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[5]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'd0);
        vecs[6]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[7]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'd0);
        vecs[8]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[9]  = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[10] = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'd0);
        vecs[11] = mk(4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
        // Frame for requester 1 with word 3C = 0011_1100. Tone is high in
        // cycles 3-5 (SHIFT), 10 (GAP), 11 (REPORT, ignored) and 13 (IDLE,
        // ignored).
        vecs[12] = mk(4'b0010, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[13] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd0);
        vecs[14] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'd0);
        vecs[15] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'd1);
        vecs[16] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'd2);
        vecs[17] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'd3);
        vecs[18] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd3);
        vecs[19] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd3);
        vecs[20] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd3);
        vecs[21] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'd3);
        vecs[22] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1, 4'd4);
        vecs[23] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4);
        vecs[24] = mk(4'b0000, 32'h0000_3C00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4);
        vecs[25] = mk(4'b0000, 32'h0000_3C00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd4);

        // ---- Reset state: reset must override active requests and Tone ----
        reset = 1'b1; req = 4'b1111; word_in = 32'hFFFF_FFFF; Tone = 1'b1;
        step(); step();
        check("reset grant",  32'(grant),      32'h0);
        check("reset done",   32'(done),       32'h0);
        check("reset tc",     32'(tone_count), 32'h0);
        check("reset busy",   32'(busy),       32'h0);
        check("reset stream", 32'(Stream),     32'h0);
        reset = 1'b0;

        // ---- Table: basic frame timing and Tone counting ----
        for (int i = 0; i < NVEC; i++) begin
            req = vecs[i].req; word_in = vecs[i].word; Tone = vecs[i].tone;
            step();
            check($sformatf("vec%0d grant", i),  32'(grant),      32'(vecs[i].grant));
            check($sformatf("vec%0d done", i),   32'(done),       32'(vecs[i].done));
            check($sformatf("vec%0d stream", i), 32'(Stream),     32'(vecs[i].stream));
            check($sformatf("vec%0d busy", i),   32'(busy),       32'(vecs[i].busy));
            check($sformatf("vec%0d tc", i),     32'(tone_count), 32'(vecs[i].tc));
        end

        // ---- Tone high for the whole frame: count reaches WORD_W+GAP ----
        // The last winner was 1, so requester 2 is checked first.
        Tone = 1'b1; req = 4'b0100; word_in = 32'h00FF_0000;
        step();
        check("tone_all grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        c = 1;
        while (done == 4'b0000 && c < 20) begin
            step();
            c++;
        end
        check("tone_all done cycle", 32'(c),          32'd11);
        check("tone_all done",       32'(done),       32'b0100);
        check("tone_all tc",         32'(tone_count), 32'd10);
        step();
        Tone = 1'b0;
        step();
        check("tone_all tc held", 32'(tone_count), 32'd10);
        check("tone_all idle",    32'(busy),       32'd0);

        // ---- All four requesting: order 0,1,2,3, one done each ----
        reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
        req = 4'b1111; word_in = 32'h1234_5678;
        for (int i = 0; i < NUM_REQ; i++) done_cnt[i] = 0;
        overlap = 0;
        for (int cy = 1; cy <= 48; cy++) begin
            step();
            if (!$onehot0(grant)) overlap++;
            if (cy % 12 == 1) check($sformatf("rr grant cyc%0d", cy), 32'(grant), 32'(1) << (cy / 12));
            if (cy % 12 == 11) check($sformatf("rr done cyc%0d", cy), 32'(done), 32'(1) << (cy / 12));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i]) begin
                    done_cnt[i]++;
                    req[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) check($sformatf("rr done count %0d", i), 32'(done_cnt[i]), 32'd1);
        check("rr grant overlap", 32'(overlap), 32'd0);
        check("rr final idle",    32'(busy),    32'd0);

        // ---- Reset in the middle of a frame, during SHIFT bit 4 ----
        reset = 1'b1; req = 4'b0000; step(); reset = 1'b0;
        req = 4'b0001; word_in = 32'h0000_00FF;
        step();
        req = 4'b0000;
        step(); step(); step();
        check("midrst pre grant", 32'(grant), 32'b0001);
        reset = 1'b1;
        step();
        check("midrst grant",  32'(grant),  32'h0);
        check("midrst stream", 32'(Stream), 32'h0);
        check("midrst busy",   32'(busy),   32'h0);
        check("midrst done",   32'(done),   32'h0);
        reset = 1'b0; req = 4'b0011;
        step();
        check("midrst regrant", 32'(grant), 32'b0001);
        req = 4'b0000;
        early_done = 0;
        for (int cy = 0; cy < 9; cy++) begin
            step();
            if (done != 4'b0000) early_done++;
        end
        check("midrst no stray done", 32'(early_done), 32'd0);
        step();
        check("midrst new done", 32'(done), 32'b0001);
        step();

        // ---- req[0] held, req[2] joins: grants alternate 0,2,0,2 ----
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0101; word_in = 32'h0000_0000;
        for (int cy = 1; cy <= 48; cy++) begin
            step();
            if (cy % 12 == 1)
                check($sformatf("alt grant cyc%0d", cy), 32'(grant),
                      ((cy / 12) % 2 == 0) ? 32'b0001 : 32'b0100);
        end
        req = 4'b0000;
        step();

        // ---- word_in changes mid-frame: Stream keeps the captured word ----
        req = 4'b0010; word_in = 32'h0000_9600;
        step();
        check("cap grant", 32'(grant), 32'b0010);
        bits[7] = Stream;
        req = 4'b0000; word_in = 32'h0000_6900;
        for (int b = 6; b >= 0; b--) begin
            step();
            bits[b] = Stream;
        end
        check("cap stream word", 32'(bits), 32'h96);
        step(); step(); step();
        check("cap done", 32'(done), 32'b0010);
        step();
        check("cap idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Shares the single-bit Stream input of the tone-detector FSM between NUM_REQ requesters.
- Each requester offers a parallel word. The block grants requesters round-robin and serializes the winning word MSB-first onto Stream.
- It counts Tone pulses returned by the FSM during the frame and reports the count to the winner with a done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per frame serialized onto Stream.
- GAP, 2, idle cycles (Stream=0) appended after each word so late Tone responses are captured (0 allowed).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- word_in  input  NUM_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- grant  output  NUM_REQ  one-hot; high for the winner from frame start through the REPORT cycle.
- done  output  NUM_REQ  one-cycle pulse to the winner in the REPORT cycle.
- tone_count  output  CNT_W=$clog2(WORD_W+GAP+1)  Tone cycles counted in the last frame.
- busy  output  1  high whenever state != IDLE.
- Stream  output  1  serial bit to the FSM Stream input.
- Tone  input  1  FSM Tone output.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; grant=0, done=0, tone_count=0, busy=0, Stream=0; shift reg and counters cleared.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority.
  - Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, SHIFT, GAP_S, REPORT.
- IDLE:
  - Stream=0.
  - If req!=0 at an edge, select the first asserted index scanning last+1, last+2, ... mod NUM_REQ.
  - At that same edge: latch winner into grant and last, load word_in slice into the shift reg, clear tone_count and the bit counter, go to SHIFT.
  - If req==0, stay in IDLE.
- SHIFT (exactly WORD_W cycles):
  - Stream = shift reg MSB (registered output); shift left one bit per cycle.
  - After WORD_W cycles go to GAP_S, or to REPORT if GAP==0.
- GAP_S (exactly GAP cycles): Stream=0.
- Tone counting:
  - Every cycle in SHIFT or GAP_S with Tone=1 increments tone_count.
  - Maximum value WORD_W+GAP fits CNT_W, so no overflow or saturation is possible.
  - Tone is ignored in IDLE and REPORT.
- REPORT (one cycle):
  - done[winner]=1; grant still held; tone_count final; Stream=0.
  - Next state IDLE; grant clears on entering IDLE.
- tone_count holds its value in IDLE until the next frame start clears it.
- Timing:
  - Request sampled at edge t: grant and first Stream bit visible in cycle t+1.
  - Bits occupy cycles t+1..t+WORD_W; gap occupies t+WORD_W+1..t+WORD_W+GAP.
  - done in cycle t+WORD_W+GAP+1; IDLE in the next cycle.
  - Back-to-back frame period is WORD_W+GAP+2 cycles (12 at defaults).
- req and word_in are sampled only at the IDLE grant edge. Dropping req mid-frame does not abort the frame. Changing word_in mid-frame has no effect.
- A winner still requesting after done is eligible again, but at lowest priority.
- Simultaneous requests are resolved only by the pointer; there is no fixed priority beyond reset.

Test Plan:
1. Defaults; req=4'b0001, word_in[7:0]=8'hA5, Tone=0 → grant=0001 from cycle 1; Stream=1,0,1,0,0,1,0,1 in cycles 1–8, then 0,0; done[0] in cycle 11 with tone_count=0; busy=0 in cycle 12.
2. After reset, req=4'b1111 held until each done → grant order 0,1,2,3; each done asserted exactly once; grant rises every 12 cycles; no overlap of grant bits.
3. Single frame; Tone high in SHIFT cycles 3–5, GAP cycle 10, and the REPORT cycle → tone_count=4 at done; value held through the following IDLE cycles.
4. Tone held high for the entire frame → tone_count=10 (WORD_W+GAP) at done; no wrap.
5. Reset asserted one cycle during SHIFT bit 4 → next cycle grant=0, Stream=0, busy=0, done never pulses. Then release reset with req=4'b0011 → requester 0 granted first.
6. req[0] held continuously, req[2] asserted from cycle 0 → grants alternate 0,2,0,2. In a separate frame, word_in for the winner is changed mid-frame → Stream still carries the word captured at the grant edge.
